alu_op_scheduler: RTL and testbench
===================================

// Module: alu_op_scheduler
// PURPOSE
//   Shares one unsigned arithmetic unit (add, sub, mul, div, mod) between NUM_REQ requesters.
//   Round-robin arbitration with valid/ready handshakes on both sides; one operation in flight.
//   add/sub/mul complete in one cycle. div/mod use an iterative restoring divider (WIDTH cycles).
//   Sits between operand producers and the result consumer in the arithmetic datapath.
// PARAMETERS
//   WIDTH    4   operand width (bits), unsigned
//   NUM_REQ  2   number of requesters, 2..4
//   RES_W    9   result width, fixed = 2*WIDTH+1
//   IDW      1   requester-id width, fixed = clog2(NUM_REQ)
// PORTS
//   clk         in   1              single clock, rising edge
//   rst_n       in   1              asynchronous, active-low reset
//   req_valid   in   NUM_REQ        per-requester request valid
//   req_ready   out  NUM_REQ        per-requester accept; at most one bit high
//   req_op      in   3*NUM_REQ      op per requester, slice i = [3*i+:3]
//   req_a       in   WIDTH*NUM_REQ  operand a per requester
//   req_b       in   WIDTH*NUM_REQ  operand b per requester
//   rsp_valid   out  1              result valid
//   rsp_ready   in   1              consumer accept
//   rsp_id      out  IDW            index of requester that issued the op
//   rsp_result  out  RES_W          result
//   rsp_err     out  1              div/mod by zero or illegal op
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - state=IDLE, rr pointer=0.
//     - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_result, rsp_err.
//     - Any in-flight op is discarded; no response for it after reset release.
//   FSM
//     - IDLE: winner = first i with req_valid[i] set, searching from pointer upward with wrap.
//       req_ready[winner]=1 combinationally; all other req_ready bits are 0.
//       req_ready is 0 in every other state.
//     - Handshake (valid&ready): capture op, a, b and id.
//       div/mod with b!=0 -> DIV; all other ops -> RESP.
//       pointer <= (winner+1) mod NUM_REQ.
//     - DIV: one quotient bit per cycle, MSB first; WIDTH cycles, then RESP.
//     - RESP: rsp_valid=1; rsp_id/rsp_result/rsp_err held stable until rsp_ready.
//       On rsp_valid&rsp_ready -> IDLE, rsp_valid=0 the next cycle.
//   Latency
//     - add/sub/mul, error cases: rsp_valid asserts 1 cycle after accept.
//     - div/mod: rsp_valid asserts WIDTH+1 cycles after accept.
//     - No new accept before the response is consumed; max throughput 1 op per 2 cycles.
//   Ops and arithmetic (unsigned, zero-extended to RES_W)
//     - 000 add: a+b (max 30).
//     - 001 sub: (a-b) mod 2^RES_W, e.g. 12-14 = 9'h1FE.
//     - 010 mul: full 2*WIDTH-bit product.
//     - 011 div: floor(a/b).
//     - 100 mod: a%b.
//     - 101..111: result 0, err=1.
//     - div/mod with b==0: result 0, err=1, no divider iteration.
//   Boundaries
//     - req_valid dropping while not granted: allowed, no effect.
//     - All req_valid low: stay IDLE, pointer unchanged.
//     - Simultaneous requests: strict rotation, no starvation.
// TESTING
//   1. req0 add a=14,b=12 -> accept cycle T; rsp_valid at T+1, result 26, id 0, err 0.
//   2. req1 sub a=12,b=14 -> result 9'h1FE; then mul 15*15 -> result 225; each latency 1.
//   3. div 15/4 -> 3 and mod 15%4 -> 3, rsp_valid exactly 5 cycles after accept;
//      div 0/0 -> result 0, err 1, latency 1; op 3'b111 -> err 1.
//   4. req0 and req1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1...;
//      req_ready never multi-hot; rsp_id matches the grant order.
//   5. rsp_ready low for 3 cycles in RESP -> rsp_* stable, req_ready all 0; release -> IDLE next cycle.
//   6. rst_n low mid-DIV -> outputs 0 immediately, no response after release;
//      next req0 add 4+2 -> 6 with pointer restarted at 0.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one unsigned add/sub/mul/div/mod unit between NUM_REQ requesters.
// One operation in flight; div/mod run on an iterative restoring divider (WIDTH cycles).
module alu_op_scheduler #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 2,
    parameter int RES_W   = 2*WIDTH+1,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [RES_W-1:0]         rsp_result,
    output logic                     rsp_err
);

    localparam int CNT_W = $clog2(WIDTH+1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     cand;
    logic [IDW-1:0]     winner;
    logic               any_valid;
    logic               accept;
    logic [2:0]         sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [RES_W-1:0]   imm_result;
    logic               imm_err;
    logic               start_div;

    logic [IDW-1:0]     id_q;
    logic [RES_W-1:0]   result_q;
    logic               err_q;
    logic               is_mod_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q, quot_q;
    logic [WIDTH-1:0]   rem_nx, quot_nx;
    logic [WIDTH:0]     rem_sh, diff;
    logic [CNT_W-1:0]   cnt_q;

    // Search from the rotation pointer upward with wrap; first valid requester wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign accept = (state_q == S_IDLE) && any_valid;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign sel_op = req_op[3*winner +: 3];
    assign sel_a  = req_a[WIDTH*winner +: WIDTH];
    assign sel_b  = req_b[WIDTH*winner +: WIDTH];

    always_comb begin
        imm_result = '0;
        imm_err    = 1'b0;
        start_div  = 1'b0;
        case (sel_op)
            3'b000: imm_result = RES_W'(sel_a) + RES_W'(sel_b);
            3'b001: imm_result = RES_W'(sel_a) - RES_W'(sel_b);
            3'b010: imm_result = RES_W'(sel_a) * RES_W'(sel_b);
            3'b011,
            3'b100: begin
                if (sel_b == '0) begin
                    imm_err = 1'b1;
                end else begin
                    start_div = 1'b1;
                end
            end
            default: imm_err = 1'b1;
        endcase
    end

    // Restoring divider step: dividend bits shift out of quot_q MSB-first into the remainder.
    always_comb begin
        rem_sh = {rem_q, quot_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (!diff[WIDTH]) begin
            rem_nx  = diff[WIDTH-1:0];
            quot_nx = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh[WIDTH-1:0];
            quot_nx = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = start_div ? S_DIV : S_RESP;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            is_mod_q <= 1'b0;
            b_q      <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            ptr_q    <= IDW'((32'(winner) + 1) % NUM_REQ);
            id_q     <= winner;
            result_q <= imm_result;
            err_q    <= imm_err;
            is_mod_q <= (sel_op == 3'b100);
            b_q      <= sel_b;
            rem_q    <= '0;
            quot_q   <= sel_a;
            cnt_q    <= CNT_W'(WIDTH-1);
        end else if (state_q == S_DIV) begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                result_q <= is_mod_q ? RES_W'(rem_nx) : RES_W'(quot_nx);
                err_q    <= 1'b0;
            end
        end
    end

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler (WIDTH=4, NUM_REQ=2) with hand-computed expectations.
module tb_alu_op_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [5:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [0:0] rsp_id;
    logic [8:0] rsp_result;
    logic       rsp_err;

    int total = 0;
    int bad   = 0;

    alu_op_scheduler #(
        .WIDTH   (4),
        .NUM_REQ (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic do_req(input int idx, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [8:0] exp_res,
                          input logic exp_err, input int exp_lat, input string tag);
        int   n;
        logic got;
        req_op[3*idx +: 3] = op;
        req_a[4*idx +: 4]  = a;
        req_b[4*idx +: 4]  = b;
        req_valid          = '0;
        req_valid[idx]     = 1'b1;
        got = 1'b0;
        n   = 0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            got = req_ready[idx];
        end
        check({tag, "_grant"}, 32'(got), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        got = 1'b0;
        n   = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            got = rsp_valid;
        end
        check({tag, "_lat"}, got ? n : 0, exp_lat);
        check({tag, "_res"}, 32'(rsp_result), 32'(exp_res));
        check({tag, "_id"},  32'(rsp_id), idx);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #3;
        check("rst_ready",  32'(req_ready), 0);
        check("rst_valid",  32'(rsp_valid), 0);
        check("rst_result", 32'(rsp_result), 0);
        check("rst_id",     32'(rsp_id), 0);
        check("rst_err",    32'(rsp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(0, 3'b000, 4'd14, 4'd12, 9'd26,   1'b0, 1, "add");
        do_req(1, 3'b001, 4'd12, 4'd14, 9'h1FE,  1'b0, 1, "sub");
        do_req(1, 3'b010, 4'd15, 4'd15, 9'd225,  1'b0, 1, "mul");
        do_req(0, 3'b011, 4'd15, 4'd4,  9'd3,    1'b0, 5, "div");
        do_req(0, 3'b100, 4'd15, 4'd4,  9'd3,    1'b0, 5, "mod");
        do_req(0, 3'b011, 4'd13, 4'd5,  9'd2,    1'b0, 5, "div2");
        do_req(0, 3'b100, 4'd13, 4'd5,  9'd3,    1'b0, 5, "mod2");
        do_req(0, 3'b011, 4'd0,  4'd0,  9'd0,    1'b1, 1, "div0");
        do_req(0, 3'b100, 4'd7,  4'd0,  9'd0,    1'b1, 1, "mod0");
        do_req(0, 3'b111, 4'd5,  4'd3,  9'd0,    1'b1, 1, "ill");

        // Pointer sits at 1 after the req0 run above: grants go 1,0,1,0.
        req_op    = {3'b000, 3'b000};
        req_a     = {4'd2, 4'd1};
        req_b     = {4'd3, 4'd1};
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            check("rr_ready", 32'(req_ready), (g % 2 == 0) ? 2 : 1);
            @(negedge clk);
            check("rr_valid", 32'(rsp_valid), 1);
            check("rr_id",    32'(rsp_id), (g % 2 == 0) ? 1 : 0);
            check("rr_res",   32'(rsp_result), (g % 2 == 0) ? 5 : 2);
        end
        @(posedge clk);
        #1 req_valid = '0;

        // Backpressure: req1 add 3+4 held for 3 cycles, req0 waiting.
        rsp_ready = 1'b0;
        req_op    = {3'b000, 3'b000};
        req_a     = {4'd3, 4'd1};
        req_b     = {4'd4, 4'd1};
        req_valid = 2'b10;
        @(negedge clk);
        check("bp_grant", 32'(req_ready), 2);
        @(posedge clk);
        #1 req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_res",   32'(rsp_result), 7);
            check("bp_id",    32'(rsp_id), 1);
            check("bp_ready", 32'(req_ready), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hold", 32'(rsp_valid), 1);
        @(negedge clk);
        check("bp_done",  32'(rsp_valid), 0);
        check("bp_idle",  32'(req_ready), 1);
        req_valid = '0;
        @(posedge clk);
        #1;

        // Reset mid-division: no response may follow, pointer restarts at 0.
        req_op[2:0] = 3'b011;
        req_a[3:0]  = 4'd15;
        req_b[3:0]  = 4'd4;
        req_valid   = 2'b01;
        @(negedge clk);
        check("rd_grant", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rd_valid", 32'(rsp_valid), 0);
        check("rd_ready", 32'(req_ready), 0);
        check("rd_res",   32'(rsp_result), 0);
        check("rd_err",   32'(rsp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rd_no_rsp", 32'(seen), 0);
        @(posedge clk);
        #1;
        req_op    = {3'b000, 3'b000};
        req_a     = {4'd1, 4'd4};
        req_b     = {4'd1, 4'd2};
        req_valid = 2'b11;
        @(negedge clk);
        check("post_grant", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("post_valid", 32'(rsp_valid), 1);
        check("post_res",   32'(rsp_result), 6);
        check("post_id",    32'(rsp_id), 0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
